// File: rtl/carry_lookahead_adder.sv
// -----------------------------------------------------------------------------
// carry_lookahead_adder
//
// Purpose:
//   Registered two-level carry-lookahead adder: {cout, s} = a + b + cin.
//   The bit-level propagate/generate terms feed 4-bit lookahead blocks.
//   A second-level lookahead unit computes every block carry-in directly
//   from cin and the group P/G terms, so no carry ripples between blocks.
//   One output register stage gives a latency of one clock. A new operand
//   set can be accepted every cycle.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset; clears s and cout
//   a     in   WIDTH  operand A (unsigned)
//   b     in   WIDTH  operand B (unsigned)
//   cin   in   1      carry into bit 0
//   s     out  WIDTH  registered sum, (a + b + cin) mod 2^WIDTH
//   cout  out  1      registered carry-out, bit WIDTH of a + b + cin
//
// WIDTH must be a multiple of 4.
// -----------------------------------------------------------------------------
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NBLK = WIDTH / 4;

    // Returns the carry out of the lowest n positions of (gv, pv) when the
    // carry-in is ci. The result is written as a flat sum of products:
    //   g[n-1] | p[n-1]&g[n-2] | ... | p[n-1]&...&p[0]&ci
    // It never reuses an intermediate carry, so each carry is one AND-OR
    // level deep rather than a ripple chain.
    function automatic logic cla_carry(input logic [WIDTH-1:0] gv,
                                       input logic [WIDTH-1:0] pv,
                                       input logic             ci,
                                       input int               n);
        logic acc;
        logic prod;
        acc  = 1'b0;
        prod = 1'b1;
        for (int j = n - 1; j >= 0; j--) begin
            acc  = acc | (gv[j] & prod);
            prod = prod & pv[j];
        end
        return acc | (prod & ci);
    endfunction

    logic [WIDTH-1:0] p;        // bit propagate
    logic [WIDTH-1:0] g;        // bit generate
    logic [NBLK-1:0]  grp_p;    // group propagate per 4-bit block
    logic [NBLK-1:0]  grp_g;    // group generate per 4-bit block
    logic [NBLK:0]    blk_c;    // carry into each block; blk_c[NBLK] = carry-out
    logic [WIDTH-1:0] c;        // carry into each bit

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    assign p = a ^ b;
    assign g = a & b;

    // First level: group P/G for each 4-bit block
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NBLK; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = cla_carry(WIDTH'(g[4*k +: 4]), WIDTH'(p[4*k +: 4]), 1'b0, 4);
        end
    end

    // Second level: every block carry is computed straight from cin and the
    // group terms. It does not take its value from the carry of the block
    // below it.
    always_comb begin
        blk_c    = '0;
        blk_c[0] = cin;
        for (int k = 0; k < NBLK; k++) begin
            blk_c[k+1] = cla_carry(WIDTH'(grp_g), WIDTH'(grp_p), cin, k + 1);
        end
    end

    // Internal block carries are expanded from the block carry-in only
    always_comb begin
        c = '0;
        for (int k = 0; k < NBLK; k++) begin
            for (int i = 0; i < 4; i++) begin
                c[4*k+i] = cla_carry(WIDTH'(g[4*k +: 4]), WIDTH'(p[4*k +: 4]),
                                     blk_c[k], i);
            end
        end
    end

    assign s_d    = p ^ c;
    assign cout_d = blk_c[NBLK];

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// -----------------------------------------------------------------------------
// tb_carry_lookahead_adder
//
// Self-checking bench for carry_lookahead_adder (WIDTH = 8).
// The bench first runs the reset sequence. It then applies the directed
// vectors back to back, followed by 1000 random vectors. One random cycle in
// the random stream asserts rst.
// The reference model is the plain integer sum of the operands applied before
// each edge, or zero on a reset edge.
// -----------------------------------------------------------------------------
module tb_carry_lookahead_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;

    int checks;
    int errors;

    carry_lookahead_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {cout,s}=%h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the registered result after an edge.
    function automatic logic [W:0] ref_model(input logic r, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic ci);
        int unsigned sum;
        if (r) return '0;
        sum = int'(av) + int'(bv) + int'(ci);
        return sum[W:0];
    endfunction

    // Drive one operand set, clock it in, then sample 1 time unit after the edge.
    task automatic apply(input string tag, input logic r, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci, input logic [W:0] exp);
        rst = r;
        a   = av;
        b   = bv;
        cin = ci;
        @(posedge clk);
        #1;
        check(tag, {cout, s}, exp);
    endtask

    // Directed vectors: a, b, cin, expected {cout, s}
    logic [W-1:0] dir_a   [7] = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'hAA, 8'hFF, 8'hFF};
    logic [W-1:0] dir_b   [7] = '{8'h00, 8'h01, 8'h01, 8'h0F, 8'h55, 8'h01, 8'hFF};
    logic         dir_cin [7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [W:0]   dir_exp [7] = '{9'h000, 9'h003, 9'h010, 9'h100, 9'h100, 9'h100, 9'h1FF};

    initial begin
        int rst_idx;
        logic         r;
        logic [W-1:0] av, bv;
        logic         ci;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        #2;

        // Reset must dominate the operands present on those edges.
        apply("reset_edge1", 1'b1, 8'hFF, 8'h01, 1'b1, 9'h000);
        apply("reset_edge2", 1'b1, 8'hFF, 8'h01, 1'b1, 9'h000);
        apply("first_after_reset", 1'b0, 8'hFF, 8'h01, 1'b1, 9'h101);

        // Directed vectors applied on consecutive cycles
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("directed%0d", i), 1'b0, dir_a[i], dir_b[i], dir_cin[i], dir_exp[i]);
        end

        // Random stream with one reset cycle placed mid-stream
        rst_idx = int'($urandom_range(100, 900));
        for (int i = 0; i < 1000; i++) begin
            r  = (i == rst_idx);
            av = W'($urandom);
            bv = W'($urandom);
            ci = 1'($urandom);
            apply(r ? $sformatf("rnd%0d_reset", i) : $sformatf("rnd%0d", i),
                  r, av, bv, ci, ref_model(r, av, bv, ci));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time in case the clock or the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d required=1010", checks);
        $fatal(1, "timeout");
    end

endmodule
